fp32_key_decode: RTL
====================

// Module: fp32_key_decode
// PURPOSE
//   Streaming inverse of the FP32 sort-key transform: turns an order-preserving 32-bit key
//   (e.g. from a sorter / top-K unit) back into an IEEE-754 FP32 word.
//   2-stage valid/ready pipeline with per-beat class flags, a per-frame ascending-order
//   checker and saturating NaN/beat statistics. Sits at the output of key-domain sort logic.
// PARAMETERS
//   CANON_NAN  1   1: any NaN output is replaced by canonical 32'h7FC00000; 0: bits pass through
//   CNT_W      16  width of statistics counters (saturating)
// PORTS
//   clk            in   1      clock
//   rst            in   1      async reset, active-high
//   in_valid       in   1      input key valid
//   in_ready       out  1      decoder can accept a key
//   in_key         in   32     sort key
//   in_last        in   1      last key of the current frame
//   out_valid      out  1      output word valid
//   out_ready      in   1      downstream accepts
//   out_x          out  32     decoded FP32 word
//   out_last       out  1      in_last delayed with its beat
//   out_is_nan     out  1      exp==FF && frac!=0 (pre-canonicalisation)
//   out_is_zero    out  1      exp==00 && frac==0 (either sign)
//   out_is_inf     out  1      exp==FF && frac==0
//   out_order_err  out  1      this beat's key < previous key of the same frame
//   err_sticky     out  1      OR of all order errors since last clear
//   stat_clr       in   1      synchronous clear of counters and err_sticky
//   cnt_beats      out  CNT_W  accepted input beats
//   cnt_nan        out  CNT_W  accepted input beats decoding to NaN
// BEHAVIOUR
// - Reset: out_valid=0, all out_* data/flags=0, err_sticky=0, counters=0, frame-start flag=1.
// - Decode: in_key[31]=1 -> x = in_key ^ 32'h80000000; in_key[31]=0 -> x = ~in_key.
//   Examples: key 80000000 -> +0, key 7FFFFFFF -> -0.
// - Pipeline: S1 registers x, flags, last, order_err; S2 is the output register.
//   Each stage loads when empty or when its consumer takes its data:
//   in_ready = !s1_valid || s2_can_load; s2_can_load = !out_valid || out_ready.
// - Latency: 2 cycles accept-to-out_valid with out_ready held 1. Throughput 1 beat/cycle.
//   No bubbles are inserted while out_ready=1.
// - Backpressure: while out_valid && !out_ready, all out_* hold stable; no beat is dropped
//   or duplicated. Worst-case capacity is 2 beats.
// - Order check (at input accept, unsigned compare on raw keys, NaN keys included):
//   - First beat after reset or after an accepted in_last beat: never flagged.
//   - Otherwise out_order_err = (in_key < prev_key); equal keys are not an error.
//   - prev_key updates on every accept.
// - err_sticky sets the cycle after an accepted erroneous beat.
// - Counters increment on input accept (in_valid && in_ready) and saturate at all-ones.
//   cnt_nan counts only when the decoded word is NaN.
// - stat_clr: counters and err_sticky go to 0 next cycle. stat_clr wins over a same-cycle
//   accept, so that beat is not counted and its order error is not made sticky.
//   stat_clr does not touch the pipeline or the frame state.
// - CANON_NAN affects out_x only; out_is_nan still reflects the decoded NaN.
// - Async reset mid-stream: in-flight beats are discarded and frame state restarts.
//   in_ready is 1 on the first clock edge after reset deassertion.
// TESTING
// 1. Keys BF800000, 407FFFFF, FF800000 back-to-back, out_ready=1:
//    -> out_x 3F800000, BF800000, 7F800000 (is_inf=1) at cycles +2, +3, +4.
// 2. Keys 80000000 and 7FFFFFFF:
//    -> out_x 00000000 and 80000000, out_is_zero=1 on both.
// 3. Key FFC00001 with CANON_NAN=1 -> out_x 7FC00000, out_is_nan=1, cnt_nan=1.
//    Same key with CANON_NAN=0 -> out_x 7FC00001.
// 4. Frame 80000001, 80000005, 80000003(last), then 80000000:
//    -> order_err only on the third beat; err_sticky=1; the fourth beat is not flagged.
// 5. Stream 8 beats with out_ready toggling 1010... and random in_valid:
//    -> output sequence equals input order exactly, out_* stable while stalled,
//       cnt_beats=8.
// 6. Assert rst with 2 beats in flight -> out_valid=0, counters=0 immediately;
//    the next frame's first beat is not order-flagged.
//    Also: stat_clr together with an accept -> counters read 0 next cycle.

Source files
------------

// File: rtl/fp32_key_decode.sv
// rtl/fp32_key_decode.sv - streaming sort-key to IEEE-754 FP32 decoder with order checking and stats
module fp32_key_decode #(
  parameter bit          CANON_NAN = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_key,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_x,
  output logic             out_last,
  output logic             out_is_nan,
  output logic             out_is_zero,
  output logic             out_is_inf,
  output logic             out_order_err,
  output logic             err_sticky,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] cnt_beats,
  output logic [CNT_W-1:0] cnt_nan
);

  logic        s1_valid;
  logic [31:0] s1_x;
  logic        s1_last, s1_nan, s1_zero, s1_inf, s1_err;

  logic [31:0] prev_key;
  logic        frame_start;

  logic        s2_can_load, accept;
  logic [31:0] dec_x;
  logic        dec_nan, dec_zero, dec_inf, dec_err;

  // Positive floats were stored with the sign flipped, negatives fully inverted.
  always_comb begin
    dec_x    = in_key[31] ? (in_key ^ 32'h8000_0000) : ~in_key;
    dec_nan  = (&dec_x[30:23]) && (|dec_x[22:0]);
    dec_inf  = (&dec_x[30:23]) && !(|dec_x[22:0]);
    dec_zero = (dec_x[30:0] == 31'd0);
    dec_err  = !frame_start && (in_key < prev_key);
  end

  assign s2_can_load = !out_valid || out_ready;
  assign in_ready    = !s1_valid || s2_can_load;
  assign accept      = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= 32'd0;
      s1_last  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_inf   <= 1'b0;
      s1_err   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x    <= (CANON_NAN && dec_nan) ? 32'h7FC0_0000 : dec_x;
        s1_last <= in_last;
        s1_nan  <= dec_nan;
        s1_zero <= dec_zero;
        s1_inf  <= dec_inf;
        s1_err  <= dec_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_key    <= 32'd0;
      frame_start <= 1'b1;
    end else if (accept) begin
      prev_key    <= in_key;
      frame_start <= in_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_x         <= 32'd0;
      out_last      <= 1'b0;
      out_is_nan    <= 1'b0;
      out_is_zero   <= 1'b0;
      out_is_inf    <= 1'b0;
      out_order_err <= 1'b0;
    end else if (s2_can_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_x         <= s1_x;
        out_last      <= s1_last;
        out_is_nan    <= s1_nan;
        out_is_zero   <= s1_zero;
        out_is_inf    <= s1_inf;
        out_order_err <= s1_err;
      end
    end
  end

  // Clear beats a same-cycle accept so software never sees a stale count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_beats  <= '0;
      cnt_nan    <= '0;
      err_sticky <= 1'b0;
    end else if (stat_clr) begin
      cnt_beats  <= '0;
      cnt_nan    <= '0;
      err_sticky <= 1'b0;
    end else if (accept) begin
      if (cnt_beats != '1) cnt_beats <= cnt_beats + CNT_W'(1);
      if (dec_nan && (cnt_nan != '1)) cnt_nan <= cnt_nan + CNT_W'(1);
      if (dec_err) err_sticky <= 1'b1;
    end
  end

endmodule
